riscv_mem_seq: RTL

- Byte-sequencing memory controller between the core's load/store path and the byte-wide riscv_bram.
- Accepts one RV32 load/store per request (LB/LH/LW/LBU/LHU/SB/SH/SW) and issues one BRAM byte access per cycle, little-endian.
- Reads: assembles and sign/zero-extends the word. Writes: splits the store data into bytes.
- Flags misaligned and illegal-funct3 requests without touching memory.

---
 rtl/riscv_mem_pkg.sv | 17 +
 rtl/riscv_bram.sv | 20 ++
 rtl/riscv_load_ext.sv | 13 +
 rtl/riscv_mem_seq.sv | 129 ++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared funct3 codes, sequencer states and access-size helper
package riscv_mem_pkg;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_seq_state_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        return funct3[1] ? 3'd4 : (funct3[0] ? 3'd2 : 3'd1);
    endfunction
endpackage

// File: rtl/riscv_bram.sv
// riscv_bram: byte-wide memory with synchronous write and combinational read
module riscv_bram #(
    parameter int ADDR_LENGTH = 5
) (
    input  logic                   clk,
    input  logic                   write_en,
    input  logic [ADDR_LENGTH-1:0] waddr,
    input  logic [7:0]             wdata,
    input  logic [ADDR_LENGTH-1:0] raddr,
    output logic [7:0]             dout
);
    logic [7:0] mem [2**ADDR_LENGTH];

    // single write port
    always_ff @(posedge clk) begin
        if (write_en) mem[waddr] <= wdata;
    end

    assign dout = mem[raddr];
endmodule

// File: rtl/riscv_load_ext.sv
// riscv_load_ext: sign/zero-extends raw load data according to funct3
module riscv_load_ext (
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] ext_o
);
    // funct3[2] selects zero extension; word loads pass through untouched
    always_comb begin
        ext_o = funct3_i[1] ? raw_i :
                funct3_i[0] ? {{16{~funct3_i[2] & raw_i[15]}}, raw_i[15:0]} :
                              {{24{~funct3_i[2] & raw_i[7]}}, raw_i[7:0]};
    end
endmodule

// File: rtl/riscv_mem_seq.sv
// riscv_mem_seq: sequences one RV32 load/store into little-endian byte BRAM accesses
module riscv_mem_seq
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_LENGTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   resp_valid,
    output logic [31:0]            resp_rdata,
    output logic                   resp_err,
    output logic                   bram_we,
    output logic [ADDR_LENGTH-1:0] bram_waddr,
    output logic [7:0]             bram_wdata,
    output logic [ADDR_LENGTH-1:0] bram_raddr,
    input  logic [7:0]             bram_dout
);
    mem_seq_state_t         state_q;
    logic                   we_q;
    logic [2:0]             f3_q;
    logic [1:0]             cnt_q;
    logic [31:0]            wdata_q;
    logic [31:0]            data_q;
    logic [31:0]            data_d;
    logic [31:0]            ext_d;
    logic                   req_ready_q;
    logic                   resp_valid_q;
    logic                   resp_err_q;
    logic [31:0]            resp_rdata_q;
    logic                   bram_we_q;
    logic [ADDR_LENGTH-1:0] bram_addr_q;
    logic [7:0]             bram_wdata_q;
    logic                   req_bad;
    logic                   last_byte;

    assign req_bad = (req_funct3[1:0] == 2'b11) || (req_funct3[2:1] == 2'b11) ||
                     (req_we && req_funct3[2]) ||
                     (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign last_byte = {1'b0, cnt_q} == size_bytes(f3_q) - 3'd1;

    // merge the byte arriving this cycle into its lane so the final byte is visible at the RESP transition
    always_comb begin
        data_d = data_q;
        data_d[{cnt_q, 3'b000} +: 8] = bram_dout;
    end

    riscv_load_ext u_ext (
        .funct3_i(f3_q),
        .raw_i   (data_d),
        .ext_o   (ext_d)
    );

    // sequencer FSM with all outputs registered; read and write share one address register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            cnt_q        <= 2'd0;
            wdata_q      <= 32'd0;
            data_q       <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: if (req_valid && req_ready_q) begin
                    we_q        <= req_we;
                    f3_q        <= req_funct3;
                    wdata_q     <= req_wdata;
                    data_q      <= 32'd0;
                    cnt_q       <= 2'd0;
                    req_ready_q <= 1'b0;
                    if (req_bad) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'd0;
                    end else begin
                        state_q      <= ACCESS;
                        bram_we_q    <= req_we;
                        bram_addr_q  <= req_addr[ADDR_LENGTH-1:0];
                        bram_wdata_q <= req_wdata[7:0];
                    end
                end
                ACCESS: begin
                    if (!we_q) data_q <= data_d;
                    cnt_q        <= cnt_q + 2'd1;
                    bram_addr_q  <= bram_addr_q + 1'b1;
                    bram_wdata_q <= wdata_q[{cnt_q + 2'd1, 3'b000} +: 8];
                    if (last_byte) begin
                        state_q      <= RESP;
                        bram_we_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= we_q ? 32'd0 : ext_d;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign bram_we    = bram_we_q;
    assign bram_waddr = bram_addr_q;
    assign bram_raddr = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
endmodule
